// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter that time-shares one and/nand, or/nor gate unit among N requesters.
// A winner's operands are captured at grant; the complementary result pair returns LAT cycles later.
module gate_unit_arbiter #(
   parameter int N   = 4,
   parameter int W   = 1,
   parameter int LAT = 2,
   parameter int IDW = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     op,
   input  logic [W*N-1:0]   a,
   input  logic [W*N-1:0]   b,
   output logic [N-1:0]     gnt,
   output logic             busy,
   output logic             done,
   output logic [IDW-1:0]   done_id,
   output logic [W-1:0]     ra,
   output logic [W-1:0]     rb
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic [IDW-1:0]     ptr, ptr_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [IDW-1:0]     win, idx;
   logic               win_vld;
   logic               cap_en;

   logic [N-1:0]       gnt_nxt;
   logic               busy_nxt, done_nxt;
   logic [IDW-1:0]     done_id_nxt;
   logic [W-1:0]       ra_nxt, rb_nxt;

   logic [W-1:0]       a_cap, b_cap;
   logic               op_cap;
   logic [IDW-1:0]     id_cap;

   function automatic logic [W-1:0] gate_base(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic         sel);
      return sel ? (x | y) : (x & y);
   endfunction

   function automatic logic [W-1:0] gate_comp(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic         sel);
      return ~gate_base(x, y, sel);
   endfunction

   // Scan from the highest offset down so the requester nearest ptr wins last-write.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = ptr + IDW'(k);
         if (req[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      gnt_nxt     = '0;
      busy_nxt    = busy;
      done_nxt    = 1'b0;
      done_id_nxt = done_id;
      ra_nxt      = ra;
      rb_nxt      = rb;
      cap_en      = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               cap_en    = 1'b1;
               ptr_nxt   = win + IDW'(1);
               gnt_nxt   = N'(1) << win;
               busy_nxt  = 1'b1;
               cnt_nxt   = CNT_W'(LAT - 1);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               ra_nxt      = gate_base(a_cap, b_cap, op_cap);
               rb_nxt      = gate_comp(a_cap, b_cap, op_cap);
               done_nxt    = 1'b1;
               done_id_nxt = id_cap;
               busy_nxt    = 1'b0;
               state_nxt   = DONE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         cnt     <= '0;
         gnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         ra      <= '0;
         rb      <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         cnt     <= cnt_nxt;
         gnt     <= gnt_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         done_id <= done_id_nxt;
         ra      <= ra_nxt;
         rb      <= rb_nxt;
      end
   end

   // Operand capture is data only; it is always reloaded before use.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         a_cap  <= a[win*W +: W];
         b_cap  <= b[win*W +: W];
         op_cap <= op[win];
         id_cap <= win;
      end
   end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Directed bench for gate_unit_arbiter (N=4, W=1, LAT=2) with hand-computed expectations.
module tb_gate_unit_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req, op, a, b;
   logic [3:0] gnt;
   logic       busy, done;
   logic [1:0] done_id;
   logic [0:0] ra, rb;

   int total = 0;
   int bad   = 0;

   gate_unit_arbiter #(.N(4), .W(1), .LAT(2), .IDW(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .op      (op),
      .a       (a),
      .b       (b),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .ra      (ra),
      .rb      (rb)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Single isolated request: grant, two busy cycles, done, then IDLE bubble.
   task automatic run_op(input int id, input logic opv, input logic av, input logic bv,
                         input logic exp_ra, input logic exp_rb);
      req     = 4'b0001 << id;
      op[id]  = opv;
      a[id]   = av;
      b[id]   = bv;
      tick;
      chk("op_gnt", 32'(gnt), 32'(4'b0001 << id));
      chk("op_busy1", 32'(busy), 32'd1);
      req = 4'b0000;
      tick;
      chk("op_busy2", 32'(busy), 32'd1);
      chk("op_gnt_off", 32'(gnt), 32'd0);
      tick;
      chk("op_done", 32'(done), 32'd1);
      chk("op_busy_off", 32'(busy), 32'd0);
      chk("op_id", 32'(done_id), 32'(id));
      chk("op_ra", 32'(ra), 32'(exp_ra));
      chk("op_rb", 32'(rb), 32'(exp_rb));
      tick;
      chk("op_done_off", 32'(done), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      req   = '0;
      op    = '0;
      a     = '0;
      b     = '0;
      tick;
      tick;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_id", 32'(done_id), 32'd0);
      chk("rst_ra", 32'(ra), 32'd0);
      chk("rst_rb", 32'(rb), 32'd0);
      reset = 1'b0;
      tick;
      chk("idle_gnt", 32'(gnt), 32'd0);

      // Basic and/nand on requester 0
      run_op(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("hold_ra", 32'(ra), 32'd1);

      // Requester 1 and/nand truth table
      run_op(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      run_op(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

      // Requester 3 or/nor
      run_op(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

      // All requesting: ptr is 0 after serving requester 3
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
         req[k % 4] = 1'b0;
         tick;
         chk("rr_busy", 32'(busy), 32'd1);
         chk("rr_no_done_busy", 32'(done), 32'd0);
         tick;
         chk("rr_done", 32'(done), 32'd1);
         chk("rr_id", 32'(done_id), 32'(k % 4));
         chk("rr_busy_off", 32'(busy), 32'd0);
         req[k % 4] = 1'b1;
         tick;
         chk("rr_bubble_gnt", 32'(gnt), 32'd0);
         chk("rr_bubble_done", 32'(done), 32'd0);
      end
      req = 4'b0000;
      tick;

      // Operand capture; ptr=1 so requester 2 wins, then req0 raised during BUSY
      op = 4'b0000;
      a  = 4'b0100;
      b  = 4'b0100;
      req = 4'b0100;
      tick;
      chk("cap_gnt", 32'(gnt), 32'b0100);
      a   = 4'b0000;
      b   = 4'b0000;
      req = 4'b0001;
      tick;
      chk("cap_busy", 32'(busy), 32'd1);
      chk("cap_ignored_gnt", 32'(gnt), 32'd0);
      tick;
      chk("cap_done", 32'(done), 32'd1);
      chk("cap_id", 32'(done_id), 32'd2);
      chk("cap_ra", 32'(ra), 32'd1);
      chk("cap_rb", 32'(rb), 32'd0);
      tick;
      chk("cap_bubble_gnt", 32'(gnt), 32'd0);
      tick;
      chk("pend_gnt", 32'(gnt), 32'b0001);
      req = 4'b0000;
      tick;
      tick;
      chk("pend_done", 32'(done), 32'd1);
      chk("pend_id", 32'(done_id), 32'd0);
      chk("pend_ra", 32'(ra), 32'd0);
      chk("pend_rb", 32'(rb), 32'd1);
      tick;

      // Reset in the second BUSY cycle aborts the op; ptr (1 here) returns to 0
      op  = 4'b0100;
      a   = 4'b0100;
      b   = 4'b0100;
      req = 4'b0100;
      tick;
      chk("abort_gnt", 32'(gnt), 32'b0100);
      req = 4'b0000;
      tick;
      chk("abort_busy2", 32'(busy), 32'd1);
      reset = 1'b1;
      tick;
      chk("abort_gnt0", 32'(gnt), 32'd0);
      chk("abort_busy0", 32'(busy), 32'd0);
      chk("abort_done0", 32'(done), 32'd0);
      chk("abort_ra0", 32'(ra), 32'd0);
      chk("abort_rb0", 32'(rb), 32'd0);
      tick;
      chk("abort_no_done", 32'(done), 32'd0);
      reset = 1'b0;
      op  = 4'b0010;
      a   = 4'b0010;
      b   = 4'b0000;
      req = 4'b1010;
      tick;
      chk("post_rst_gnt", 32'(gnt), 32'b0010);
      req = 4'b1000;
      tick;
      tick;
      chk("post_rst_done", 32'(done), 32'd1);
      chk("post_rst_id", 32'(done_id), 32'd1);
      chk("post_rst_ra", 32'(ra), 32'd1);
      chk("post_rst_rb", 32'(rb), 32'd0);
      tick;
      tick;
      chk("post_rst_next_gnt", 32'(gnt), 32'b1000);
      req = 4'b0000;
      tick;
      tick;
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
